// File: rtl/ahb_mtx_input_stage.sv
// ahb_mtx_input_stage
// Per-master input stage of the AHB bus matrix. Samples each address phase
// from the master and presents it as a request to the output-port arbiters.
// When the output stage cannot take the transfer in its sample cycle, the
// transfer is held in a register and the master is stalled. Data-phase
// ready and response from the granted output stage are returned to the master.
//
// Ports:
//   HCLK, HRESET             clock, asynchronous active-high reset
//   HSELS .. HMASTLOCKS      address phase from the master
//   HREADYS                  bus HREADY seen by this port
//   HREADYOUTS, HRESPS       ready / response back to the master
//   req_out, *_out           request + address phase to the output stages
//   addr_accept              output stage takes the address phase this cycle
//   data_ready_in/resp_in    data-phase ready / response from the output stage
//   pend_cycles              stall monitor
//
// Optional feature: define AHB_MTX_PEND_MON_EN to build the pend_cycles
// counter; otherwise pend_cycles is tied to zero.
module ahb_mtx_input_stage #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic [1:0]        HRESPS,
  output logic              req_out,
  output logic              sel_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [1:0]        trans_out,
  output logic              write_out,
  output logic [2:0]        size_out,
  output logic [2:0]        burst_out,
  output logic [3:0]        prot_out,
  output logic              mastlock_out,
  input  logic              addr_accept,
  input  logic              data_ready_in,
  input  logic [1:0]        data_resp_in,
  output logic [7:0]        pend_cycles
);

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef struct packed {
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        trans;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
    logic              mastlock;
  } aphase_t;

  state_t  state;
  aphase_t hold;
  aphase_t live;
  aphase_t out_ph;
  logic    sampled;
  logic    capture;

  // Live address phase from the master
  assign live = '{sel: HSELS, addr: HADDRS, trans: HTRANSS, write: HWRITES,
                  size: HSIZES, burst: HBURSTS, prot: HPROTS, mastlock: HMASTLOCKS};

  // NONSEQ/SEQ only; IDLE and BUSY are answered locally with zero-wait OKAY
  assign sampled = HSELS & HREADYS & HTRANSS[1];

  // A new transfer is sampled but the output stage cannot take it now
  assign capture = sampled & ~addr_accept &
                   ((state == ST_IDLE) | ((state == ST_DATA) & data_ready_in));

  // State register and hold register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= ST_IDLE;
      hold  <= '0;
    end else begin
      if (capture) begin
        hold <= live;
      end
      case (state)
        ST_IDLE: begin
          if (sampled) begin
            state <= addr_accept ? ST_DATA : ST_PEND;
          end
        end
        ST_PEND: begin
          if (addr_accept) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          // Completion and a new sample in the same cycle are handled on one edge
          if (data_ready_in) begin
            if (sampled) begin
              state <= addr_accept ? ST_DATA : ST_PEND;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Address phase to the output stages: registered while pending, live otherwise
  assign out_ph       = (state == ST_PEND) ? hold : live;
  assign req_out      = (state == ST_PEND) ? 1'b1 : sampled;
  assign sel_out      = out_ph.sel;
  assign addr_out     = out_ph.addr;
  assign trans_out    = out_ph.trans;
  assign write_out    = out_ph.write;
  assign size_out     = out_ph.size;
  assign burst_out    = out_ph.burst;
  assign prot_out     = out_ph.prot;
  assign mastlock_out = out_ph.mastlock;

  // Master-side ready/response; reset forces IDLE so HREADYOUTS rises asynchronously
  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = RESP_OKAY;
    case (state)
      ST_PEND: HREADYOUTS = 1'b0;
      ST_DATA: begin
        HREADYOUTS = data_ready_in;
        HRESPS     = data_resp_in;
      end
      default: begin
        HREADYOUTS = 1'b1;
        HRESPS     = RESP_OKAY;
      end
    endcase
  end

`ifdef AHB_MTX_PEND_MON_EN
  logic [7:0] pend_cnt;

  // Loads 1 on PEND entry, counts further PEND cycles, saturates, holds after exit
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pend_cnt <= '0;
    end else if (capture) begin
      pend_cnt <= 8'd1;
    end else if ((state == ST_PEND) && !addr_accept && (pend_cnt != 8'hFF)) begin
      pend_cnt <= pend_cnt + 8'd1;
    end
  end

  assign pend_cycles = pend_cnt;
`else
  assign pend_cycles = '0;
`endif

endmodule

// File: doc/ahb_mtx_input_stage.md
# ahb_mtx_input_stage

Per-master input stage of the AHB bus matrix, sitting directly upstream of the output-port arbiters and output stages. It samples each address phase from its master and presents it to the output stages as a request, the `req_portN` input of each arbiter. When the selected output port cannot take the transfer in the same cycle, it holds the transfer in a register and stalls the master. It also returns the data-phase ready and response from the granted output stage back to the master.

## Interface
Parameters:
- `ADDR_W`, default 32, address width.

Ports:
- `HCLK` in 1: AHB clock.
- `HRESET` in 1: AHB reset, asynchronous, active-high.
- `HSELS` in 1: select from the master-side decoder.
- `HADDRS` in `ADDR_W`: address.
- `HTRANSS` in 2: transfer type.
- `HWRITES` in 1: write.
- `HSIZES` in 3: size.
- `HBURSTS` in 3: burst type.
- `HPROTS` in 4: protection.
- `HMASTLOCKS` in 1: locked transfer.
- `HREADYS` in 1: bus HREADY seen by this port.
- `HREADYOUTS` out 1: ready to the master.
- `HRESPS` out 2: response to the master.
- `req_out` out 1: transfer request to the output arbiters.
- `sel_out`, `addr_out`, `trans_out`, `write_out`, `size_out`, `burst_out`, `prot_out`, `mastlock_out` out (widths as inputs): address phase presented to the output stages.
- `addr_accept` in 1: the output stage takes the presented address phase this cycle (grant & HREADYM).
- `data_ready_in` in 1: data-phase ready from the granted output stage.
- `data_resp_in` in 2: data-phase response from the granted output stage.
- `pend_cycles` out 8: stall monitor (see Configuration).

## Operation
Sampling:
- A transfer is sampled when `HSELS & HREADYS & HTRANSS[1]` (NONSEQ or SEQ).
- IDLE and BUSY transfers with `HSELS` set get a zero-wait OKAY and are never held or forwarded.

FSM states: IDLE, PEND, DATA.
- **IDLE**
  - Sampled & `addr_accept` → DATA.
  - Sampled & !`addr_accept` → PEND; all address-phase inputs are captured into the hold register.
  - Otherwise stay in IDLE.
- **PEND**
  - `addr_accept` → DATA.
  - Otherwise stay in PEND.
  - The master is stalled and cannot drive a new transfer.
- **DATA**
  - !`data_ready_in` → stay in DATA.
  - `data_ready_in` & sampled & `addr_accept` → DATA.
  - `data_ready_in` & sampled & !`addr_accept` → PEND, with capture.
  - `data_ready_in` & not sampled → IDLE.

Outputs:
- In PEND, the address outputs come from the hold register and `req_out`=1.
- Otherwise the address outputs pass the live master inputs, and `req_out` = `HSELS & HREADYS & HTRANSS[1]`.
- `HREADYOUTS`: 1 in IDLE, 0 in PEND, `data_ready_in` in DATA.
- `HRESPS`: OKAY (2'b00) in IDLE and PEND; `data_resp_in` in DATA, including both cycles of a two-cycle ERROR.
- The hold register loads only on capture and is never cleared on exit.

## Timing
- Reset values: state IDLE; hold register all 0; `HREADYOUTS`=1; `HRESPS`=2'b00; `pend_cycles`=0. `req_out`=0 while `HSELS`=0.
- Zero-latency path: a transfer accepted in its sample cycle reaches the output stage with no added cycle.
- Each PEND cycle adds one wait state to the master.
- `req_out` and the address outputs are combinational from the master inputs outside PEND, and registered in PEND.
- `addr_accept` is combinational from the output stage in the same cycle.
- Simultaneous data completion and new sample in DATA: the old data phase ends and the new transfer is handled in the same edge.
- `HRESET` asserted mid-transfer: immediate return to IDLE. The held transfer is discarded and `HREADYOUTS` goes to 1 asynchronously.

## Configuration
Macro `AHB_MTX_PEND_MON_EN`.
- **Defined:**
  - `pend_cycles` is an 8-bit counter that loads 1 on entry to PEND.
  - It increments on each further PEND cycle and saturates at 255.
  - It holds its value after PEND exits until the next PEND entry.
- **Not defined:** `pend_cycles` is tied to 0 and no counter flops exist.

## Test plan
- Reset mid-PEND: assert `HRESET` → `HREADYOUTS`=1, `req_out`=0 with `HSELS`=0, `HRESPS`=OKAY, and the state returns to IDLE.
- NONSEQ write to 0x2000_0000 with `addr_accept`=1:
  - Same cycle: `addr_out`=0x2000_0000 and `req_out`=1.
  - With `data_ready_in` low for 2 cycles, the master sees 2 wait states, then OKAY.
- NONSEQ read to 0x0000_0100 with `addr_accept`=0 for 3 cycles, then 1:
  - The hold register drives `addr_out`=0x0000_0100 while the master inputs change to garbage.
  - `HREADYOUTS` is low for the 3 PEND cycles plus the data phase.
  - `pend_cycles`=3 (macro on) or 0 (macro off).
- Back-to-back SEQ burst INCR4: `data_ready_in`=1 with `addr_accept` toggling 1,0,1,1 → exactly one PEND entry. Beat order and addresses must be preserved.
- `HSELS`=1 with `HTRANSS`=IDLE or BUSY → `req_out`=0, `HREADYOUTS`=1, `HRESPS`=OKAY, and no state change.
- Two-cycle ERROR: `data_resp_in`=2'b01 with `data_ready_in` 0 then 1 → `HRESPS`=ERROR in both cycles, `HREADYOUTS`=0 then 1, then IDLE.
